// File: rtl/scarv_cop_insn_buf_pkg.sv
// Shared types and constants for the XCrypto COP instruction buffer:
// FSM state encoding and the execution result codes.
package scarv_cop_insn_buf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  localparam logic [2:0] SCARV_COP_RSLT_SUCCESS = 3'b000;
  localparam logic [2:0] SCARV_COP_RSLT_TIMEOUT = 3'b111;

endpackage

// File: rtl/scarv_cop_watchdog.sv
// Clear/enable/expire cycle counter; expire flags the TIMEOUT_CYCLES-th
// consecutive enabled cycle since the last clear.
module scarv_cop_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)  cnt <= '0;
    else if (en)     cnt <= cnt + 1'b1;
  end

  assign expire = en && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/scarv_cop_insn_buf.sv
// COP instruction buffer: accept, issue to decode, capture execute result,
// hold response until CPU ack. Optional watchdog: SCARV_COP_INSN_TIMEOUT_EN.
module scarv_cop_insn_buf
  import scarv_cop_insn_buf_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        cpu_insn_req,
  output logic        cop_insn_ack,
  input  logic        cpu_abort_req,
  input  logic [31:0] cpu_insn_enc,
  input  logic [31:0] cpu_rs1,
  output logic        cop_wen,
  output logic [4:0]  cop_waddr,
  output logic [31:0] cop_wdata,
  output logic [2:0]  cop_result,
  output logic        cop_insn_rsp,
  input  logic        cpu_insn_ack,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_enc,
  output logic [31:0] id_rs1,
  input  logic        ex_done,
  input  logic        ex_wen,
  input  logic [4:0]  ex_waddr,
  input  logic [31:0] ex_wdata,
  input  logic [2:0]  ex_result,
  output logic        busy
);

  state_t      state, state_nxt;
  logic        discard, discard_nxt;
  logic        lat_req, lat_ex, lat_tmo;
  logic        tmo;
  logic        wen_q;
  logic [4:0]  waddr_q;
  logic [31:0] wdata_q;
  logic [2:0]  result_q;

`ifdef SCARV_COP_INSN_TIMEOUT_EN
  scarv_cop_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk    (g_clk),
    .rst    (g_reset),
    .clr    (state != ST_WAIT),
    .en     (state == ST_WAIT),
    .expire (tmo)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    discard_nxt  = discard;
    lat_req      = 1'b0;
    lat_ex       = 1'b0;
    lat_tmo      = 1'b0;
    cop_insn_ack = 1'b0;
    case (state)
      ST_IDLE: begin
        cop_insn_ack = cpu_insn_req;
        if (cpu_insn_req) begin
          lat_req   = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cpu_abort_req) state_nxt = ST_IDLE;
        else if (id_ready) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // Abort coinciding with completion/timeout still discards the result.
        if (ex_done || tmo) begin
          if (discard || cpu_abort_req) begin
            discard_nxt = 1'b0;
            state_nxt   = ST_HOLD;
          end else begin
            lat_ex    = ex_done;
            lat_tmo   = !ex_done;
            state_nxt = ST_RESP;
          end
        end else if (cpu_abort_req) begin
          discard_nxt = 1'b1;
        end
      end
      ST_RESP: begin
        if (cpu_insn_ack) state_nxt = ST_HOLD;
      end
      ST_HOLD: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state    <= ST_IDLE;
      discard  <= 1'b0;
      id_enc   <= '0;
      id_rs1   <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      result_q <= SCARV_COP_RSLT_SUCCESS;
    end else begin
      state   <= state_nxt;
      discard <= discard_nxt;
      if (lat_req) begin
        id_enc <= cpu_insn_enc;
        id_rs1 <= cpu_rs1;
      end
      if (lat_ex) begin
        wen_q    <= ex_wen;
        waddr_q  <= ex_waddr;
        wdata_q  <= ex_wdata;
        result_q <= ex_result;
      end else if (lat_tmo) begin
        wen_q    <= 1'b0;
        result_q <= SCARV_COP_RSLT_TIMEOUT;
      end
    end
  end

  assign cop_insn_rsp = (state == ST_RESP);
  assign cop_wen      = cop_insn_rsp && wen_q;
  assign cop_waddr    = waddr_q;
  assign cop_wdata    = wdata_q;
  assign cop_result   = result_q;
  assign id_valid     = (state == ST_ISSUE);
  assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_scarv_cop_insn_buf.sv
// Bench for scarv_cop_insn_buf: directed and randomized transactions checked
// against a per-transaction timeline derived from the protocol rules.
module tb_scarv_cop_insn_buf;

  logic        g_clk = 1'b0;
  logic        g_reset = 1'b1;
  logic        cpu_insn_req = 0, cpu_abort_req = 0, cpu_insn_ack = 0;
  logic [31:0] cpu_insn_enc = 0, cpu_rs1 = 0;
  logic        id_ready = 0, ex_done = 0, ex_wen = 0;
  logic [4:0]  ex_waddr = 0;
  logic [31:0] ex_wdata = 0;
  logic [2:0]  ex_result = 0;
  logic        cop_insn_ack, cop_wen, cop_insn_rsp, id_valid, busy;
  logic [4:0]  cop_waddr;
  logic [31:0] cop_wdata, id_enc, id_rs1;
  logic [2:0]  cop_result;

  int total = 0;
  int bad = 0;

  always #5 g_clk = ~g_clk;

  scarv_cop_insn_buf #(.TIMEOUT_CYCLES(8)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .cpu_insn_req(cpu_insn_req), .cop_insn_ack(cop_insn_ack),
    .cpu_abort_req(cpu_abort_req), .cpu_insn_enc(cpu_insn_enc), .cpu_rs1(cpu_rs1),
    .cop_wen(cop_wen), .cop_waddr(cop_waddr), .cop_wdata(cop_wdata),
    .cop_result(cop_result), .cop_insn_rsp(cop_insn_rsp), .cpu_insn_ack(cpu_insn_ack),
    .id_valid(id_valid), .id_ready(id_ready), .id_enc(id_enc), .id_rs1(id_rs1),
    .ex_done(ex_done), .ex_wen(ex_wen), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .ex_result(ex_result), .busy(busy)
  );

  task automatic cyc();
    @(posedge g_clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_insn_req = 0; cpu_abort_req = 0; cpu_insn_ack = 0; id_ready = 0; ex_done = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    g_reset = 1;
    repeat (3) cyc();
    g_reset = 0;
    #1;
    total++; if ({cop_insn_ack, cop_wen, cop_insn_rsp, id_valid, busy} !== 5'b0) begin bad++; $display("FAIL reset ctl got %b want 00000", {cop_insn_ack, cop_wen, cop_insn_rsp, id_valid, busy}); end
    total++; if ({cop_waddr, cop_wdata, cop_result, id_enc, id_rs1} !== '0) begin bad++; $display("FAIL reset data got %h want 0", {cop_waddr, cop_wdata, cop_result, id_enc, id_rs1}); end
    cyc();
  endtask

  // mode 0: normal, 1: abort in ISSUE, 2: abort on WAIT entry.
  // Timeline: t0 accept, ISSUE t1..1+bp, WAIT from tw, ex_done at td,
  // response from td+1 for ackd+1 cycles, one HOLD cycle, then IDLE.
  task automatic test_txn(input string nm, input logic [31:0] enc, input logic [31:0] rs1,
                          input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                          input logic [2:0] rs, input int bp, input int exd, input int mode,
                          input int ackd, input bit hold, input bit spur);
    int tw, td, tr, th, tend;
    logic e_ack, e_ivld, e_rsp, e_busy;
    tw = 2 + bp; td = tw + exd; tr = td + 1;
    th = (mode == 0) ? tr + ackd + 1 : td + 1;
    tend = (mode == 1) ? 2 : th + 1;
    for (int t = 0; t <= tend; t++) begin
      cpu_insn_req  = (t == 0) || (hold && mode == 0 && t >= tr && t <= th);
      cpu_insn_enc  = (t == 0) ? enc : $urandom;
      cpu_rs1       = (t == 0) ? rs1 : $urandom;
      id_ready      = (mode == 1) ? (t == 1) : (t >= 1 + bp);
      cpu_abort_req = (mode == 1 && t == 1) || (mode == 2 && t == tw) || (mode == 0 && t == tr);
      ex_done       = (mode != 1 && t == td) || (t == 1 && spur);
      ex_wen        = (t == td) ? wen : 1'($urandom);
      ex_waddr      = (t == td) ? wa  : 5'($urandom);
      ex_wdata      = (t == td) ? wd  : $urandom;
      ex_result     = (t == td) ? rs  : 3'($urandom);
      cpu_insn_ack  = (t == tr + ackd);
      #1;
      e_ack  = (t == 0);
      e_ivld = (mode == 1) ? (t == 1) : (t >= 1 && t <= 1 + bp);
      e_rsp  = (mode == 0) && t >= tr && t <= tr + ackd;
      e_busy = (mode == 1) ? (t == 1) : (t >= 1 && t <= th);
      total++; if (cop_insn_ack !== e_ack) begin bad++; $display("FAIL %s t=%0d ack got %b want %b", nm, t, cop_insn_ack, e_ack); end
      total++; if (id_valid !== e_ivld) begin bad++; $display("FAIL %s t=%0d id_valid got %b want %b", nm, t, id_valid, e_ivld); end
      total++; if (cop_insn_rsp !== e_rsp) begin bad++; $display("FAIL %s t=%0d rsp got %b want %b", nm, t, cop_insn_rsp, e_rsp); end
      total++; if (cop_wen !== (e_rsp && wen)) begin bad++; $display("FAIL %s t=%0d wen got %b want %b", nm, t, cop_wen, e_rsp && wen); end
      total++; if (busy !== e_busy) begin bad++; $display("FAIL %s t=%0d busy got %b want %b", nm, t, busy, e_busy); end
      if (t >= 1) begin
        total++; if ({id_enc, id_rs1} !== {enc, rs1}) begin bad++; $display("FAIL %s t=%0d id_enc/rs1 got %h/%h want %h/%h", nm, t, id_enc, id_rs1, enc, rs1); end
      end
      if (e_rsp) begin
        total++; if ({cop_waddr, cop_wdata, cop_result} !== {wa, wd, rs}) begin bad++; $display("FAIL %s t=%0d rsp data got %h/%h/%h want %h/%h/%h", nm, t, cop_waddr, cop_wdata, cop_result, wa, wd, rs); end
      end
      cyc();
    end
    idle_inputs();
  endtask

  task automatic test_reset_wait();
    idle_inputs();
    cpu_insn_req = 1; cpu_insn_enc = 32'hCAFE_F00D; cpu_rs1 = 32'h0BAD_0BAD; id_ready = 1;
    cyc();
    cpu_insn_req = 0;
    cyc();
    total++; if (busy !== 1'b1 || id_valid !== 1'b0) begin bad++; $display("FAIL reset_wait pre busy/id_valid got %b/%b want 1/0", busy, id_valid); end
    g_reset = 1;
    cyc();
    g_reset = 0; id_ready = 0;
    #1;
    total++; if ({cop_insn_ack, cop_wen, cop_insn_rsp, id_valid, busy} !== 5'b0) begin bad++; $display("FAIL reset_wait ctl got %b want 00000", {cop_insn_ack, cop_wen, cop_insn_rsp, id_valid, busy}); end
    total++; if ({cop_waddr, cop_wdata, cop_result, id_enc, id_rs1} !== '0) begin bad++; $display("FAIL reset_wait data got %h want 0", {cop_waddr, cop_wdata, cop_result, id_enc, id_rs1}); end
    cyc();
  endtask

`ifdef SCARV_COP_INSN_TIMEOUT_EN
  task automatic test_timeout();
    idle_inputs();
    cpu_insn_req = 1; cpu_insn_enc = 32'h0000_700B; cpu_rs1 = 32'h1; id_ready = 1;
    cyc();
    cpu_insn_req = 0;
    cyc();
    // t=2 is the first WAIT cycle; response expected after 8 WAIT cycles.
    for (int t = 2; t <= 10; t++) begin
      total++; if (cop_insn_rsp !== (t == 10)) begin bad++; $display("FAIL timeout t=%0d rsp got %b want %b", t, cop_insn_rsp, t == 10); end
      if (t < 10) cyc();
    end
    total++; if (cop_result !== 3'b111 || cop_wen !== 1'b0) begin bad++; $display("FAIL timeout result/wen got %b/%b want 111/0", cop_result, cop_wen); end
    cpu_insn_ack = 1;
    cyc();
    cpu_insn_ack = 0; ex_done = 1; ex_wen = 1; ex_result = 3'b001;
    cyc();
    ex_done = 0;
    #1;
    total++; if (busy !== 1'b0 || cop_insn_rsp !== 1'b0 || cop_result !== 3'b111) begin bad++; $display("FAIL timeout late ex_done busy/rsp/result got %b/%b/%b want 0/0/111", busy, cop_insn_rsp, cop_result); end
    cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_txn("basic", 32'h0000_600B, 32'h1234_5678, 1, 5'd5, 32'hDEAD_BEEF, 3'd0, 0, 0, 0, 0, 0, 0);
    test_txn("held_req", 32'h0000_610B, 32'h0000_0042, 1, 5'd7, 32'h0123_4567, 3'd0, 0, 0, 0, 0, 1, 0);
    test_txn("backpressure", 32'h0000_620B, 32'hA5A5_A5A5, 0, 5'd9, 32'h7777_0000, 3'd2, 4, 1, 0, 0, 0, 0);
    test_txn("abort_issue", 32'h0000_630B, 32'h5555_AAAA, 1, 5'd3, 32'h1111_2222, 3'd0, 0, 0, 1, 0, 0, 1);
    test_txn("abort_wait", 32'h0000_640B, 32'h0F0F_0F0F, 1, 5'd4, 32'h3333_4444, 3'd0, 0, 3, 2, 0, 0, 0);
    test_txn("delayed_ack", 32'h0000_650B, 32'hFFFF_0001, 1, 5'd31, 32'h8000_0001, 3'd5, 0, 0, 0, 2, 1, 0);
    for (int n = 0; n < 40; n++)
      test_txn("random", $urandom, $urandom, 1'($urandom), 5'($urandom), $urandom, 3'($urandom),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom));
    test_reset_wait();
    test_txn("after_reset", 32'h0000_660B, 32'h2468_ACE0, 1, 5'd1, 32'h1357_9BDF, 3'd0, 1, 2, 0, 1, 0, 0);
`ifdef SCARV_COP_INSN_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
